// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game blocks: checker FSM states and the
// one-hot colour encoding used by the sequence decoder and colour display.
package genius_pkg;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESPERA_SOLTAR = 2'd1,
    ESPERA_TECLA  = 2'd2,
    FALHA         = 2'd3
  } estado_t;

  localparam logic [3:0] COR_VERDE    = 4'b0001;
  localparam logic [3:0] COR_VERMELHO = 4'b0010;
  localparam logic [3:0] COR_AZUL     = 4'b0100;
  localparam logic [3:0] COR_AMARELO  = 4'b1000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Timeout counter: clears on request, counts while enabled and stops at
// TIMEOUT_CYCLES-1, where fim is raised.
module contador_tempo #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa,
  input  logic habilita,
  output logic fim
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (limpa)           cnt <= '0;
    else if (habilita && !fim) cnt <= cnt + W'(1);
  end

  assign fim = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/verificador_jogada.sv
// Genius player-input checker: edge-detects button presses, compares them to
// the decoder's expected colour and walks the sequence address.
module verificador_jogada
  import genius_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] esperado,
  output logic [3:0] endereco,
  output logic       acerto,
  output logic       erro,
  output logic       erro_tempo,
  output logic       rodada_ok,
  output logic       ativo
);

  estado_t    estado;
  logic [3:0] nivel_q;
  logic [3:0] botoes_q;
  logic       fim;
  logic       press;
  logic       confere;

  // Counter only runs while waiting for a press; any other state holds it at 0.
  contador_tempo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tempo (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpa    (start || (estado != ESPERA_TECLA)),
    .habilita (estado == ESPERA_TECLA),
    .fim      (fim)
  );

  assign press   = (botoes != 4'b0000) && (botoes_q == 4'b0000);
  assign confere = (botoes == esperado) && is_onehot(esperado);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      endereco   <= 4'd0;
      nivel_q    <= 4'd0;
      botoes_q   <= 4'd0;
      acerto     <= 1'b0;
      erro       <= 1'b0;
      erro_tempo <= 1'b0;
      rodada_ok  <= 1'b0;
      ativo      <= 1'b0;
    end else begin
      botoes_q   <= botoes;
      acerto     <= 1'b0;
      erro       <= 1'b0;
      erro_tempo <= 1'b0;
      rodada_ok  <= 1'b0;
      if (start) begin
        endereco <= 4'd0;
        nivel_q  <= nivel;
        estado   <= ESPERA_SOLTAR;
        ativo    <= 1'b1;
      end else begin
        case (estado)
          ESPERA_SOLTAR: if (botoes == 4'b0000) estado <= ESPERA_TECLA;
          ESPERA_TECLA: begin
            if (press) begin
              if (confere) begin
                acerto <= 1'b1;
                // Last step: stop on this address instead of incrementing.
                if (endereco == nivel_q) begin
                  rodada_ok <= 1'b1;
                  estado    <= OCIOSO;
                  ativo     <= 1'b0;
                end else begin
                  endereco <= endereco + 4'd1;
                  estado   <= ESPERA_SOLTAR;
                end
              end else begin
                erro   <= 1'b1;
                estado <= FALHA;
                ativo  <= 1'b0;
              end
            end else if (fim) begin
              erro       <= 1'b1;
              erro_tempo <= 1'b1;
              estado     <= FALHA;
              ativo      <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
